// File: rtl/wb_sram_slave_if.sv
// -----------------------------------------------------------------------------
// wb_sram_slave_if
//
// Wishbone classic single-access bus bundle between the AHB-to-Wishbone bridge
// (master side) and the SRAM slave.
//
// Signals (names are from the slave's point of view):
//   adr_i  [AWIDTH]  word address, master -> slave
//   dat_i  [DWIDTH]  write data,   master -> slave
//   we_i             1 = write,    master -> slave
//   stb_i            strobe,       master -> slave
//   cyc_i            bus cycle,    master -> slave
//   dat_o  [DWIDTH]  read data,    slave -> master
//   ack_o            normal termination, slave -> master
//   err_o            error termination,  slave -> master
// -----------------------------------------------------------------------------
interface wb_sram_slave_if #(
  parameter int AWIDTH = 16,
  parameter int DWIDTH = 32
);

  logic [AWIDTH-1:0] adr_i;
  logic [DWIDTH-1:0] dat_i;
  logic [DWIDTH-1:0] dat_o;
  logic              we_i;
  logic              stb_i;
  logic              cyc_i;
  logic              ack_o;
  logic              err_o;

  modport master (
    output adr_i,
    output dat_i,
    output we_i,
    output stb_i,
    output cyc_i,
    input  dat_o,
    input  ack_o,
    input  err_o
  );

  modport slave (
    input  adr_i,
    input  dat_i,
    input  we_i,
    input  stb_i,
    input  cyc_i,
    output dat_o,
    output ack_o,
    output err_o
  );

endinterface : wb_sram_slave_if

// File: rtl/wb_sram_slave.sv
// -----------------------------------------------------------------------------
// wb_sram_slave
//
// Wishbone classic single-access slave sitting behind the AHB-to-Wishbone
// bridge. It holds a word-addressed synchronous RAM of 2**DEPTH_LOG2 words,
// inserts WAIT_STATES extra cycles before each response, and answers accesses
// outside its address window with err_o instead of ack_o. Exactly one response
// is produced per strobe assertion.
//
// Ports:
//   clk_i   clock, rising edge
//   rst_i   synchronous, active-high reset
//   wb      wb_sram_slave_if.slave bundle (adr_i, dat_i, we_i, stb_i, cyc_i in;
//           dat_o, ack_o, err_o out)
//
// Parameters:
//   AWIDTH       address width (matches the bridge)
//   DWIDTH       data width (matches the bridge)
//   DEPTH_LOG2   log2 of RAM depth in words
//   WAIT_STATES  extra cycles before the response, 0..15
//   BASE_ADDR    window base; only bits [AWIDTH-1:DEPTH_LOG2] are compared
// -----------------------------------------------------------------------------
module wb_sram_slave #(
  parameter int                AWIDTH      = 16,
  parameter int                DWIDTH      = 32,
  parameter int                DEPTH_LOG2  = 8,
  parameter int                WAIT_STATES = 1,
  parameter logic [AWIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic           clk_i,
  input  logic           rst_i,
  wb_sram_slave_if.slave wb
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // The counter runs from WAIT_STATES-1 down to 0; with no wait states it is
  // never loaded with anything but zero.
  localparam logic [3:0] CNT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    HOLD
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [3:0]              cnt;

  logic [AWIDTH-1:0]       adr_q;
  logic [DWIDTH-1:0]       dat_q;
  logic                    we_q;
  logic                    hit_q;
  logic [DWIDTH-1:0]       rd_data;

  logic                    req;
  logic                    enter_resp;
  logic                    ack;
  logic                    err;

  logic [AWIDTH-1:0]       acc_adr;
  logic [DWIDTH-1:0]       acc_dat;
  logic                    acc_we;
  logic                    acc_hit;
  logic [DEPTH_LOG2-1:0]   acc_idx;

  logic [DWIDTH-1:0]       mem [DEPTH];

  assign req = wb.cyc_i & wb.stb_i;

  // Access operands: with zero wait states the RAM is touched on the very
  // edge that samples the request, before the latches hold anything, so in
  // IDLE the live bus is used. In every other state the latched copy is used,
  // which makes later changes of adr_i/dat_i/we_i irrelevant to the access.
  always_comb begin
    acc_adr = adr_q;
    acc_dat = dat_q;
    acc_we  = we_q;
    if (state == IDLE) begin
      acc_adr = wb.adr_i;
      acc_dat = wb.dat_i;
      acc_we  = wb.we_i;
    end
    acc_hit = (acc_adr[AWIDTH-1:DEPTH_LOG2] == BASE_ADDR[AWIDTH-1:DEPTH_LOG2]);
    acc_idx = acc_adr[DEPTH_LOG2-1:0];
  end

  // Next-state and response decode. enter_resp marks the edge on which the
  // RAM is accessed; the response itself is visible for the single RESP cycle
  // that follows. HOLD swallows a strobe that stays high after the response.
  always_comb begin
    state_nxt  = state;
    enter_resp = 1'b0;
    ack        = 1'b0;
    err        = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt  = WAIT;
          end
        end
      end
      WAIT: begin
        if (!wb.cyc_i) begin
          state_nxt = IDLE;
        end else if (cnt == 4'd0) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        state_nxt = HOLD;
        ack       = hit_q;
        err       = ~hit_q;
      end
      HOLD: begin
        if (!wb.stb_i || !wb.cyc_i) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, wait counter, request latches and the read-data register.
  // dat_o only changes on a hit read, so it keeps the last read value across
  // writes, misses and idle time.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      hit_q   <= 1'b0;
      rd_data <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req) begin
        adr_q <= wb.adr_i;
        dat_q <= wb.dat_i;
        we_q  <= wb.we_i;
        hit_q <= acc_hit;
        cnt   <= CNT_LOAD;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp && acc_hit && !acc_we) begin
        rd_data <= mem[acc_idx];
      end
    end
  end

  // RAM write port. Contents survive reset; a reset coinciding with the
  // access edge cancels the write so a reset access leaves no trace.
  always_ff @(posedge clk_i) begin
    if (!rst_i && enter_resp && acc_hit && acc_we) begin
      mem[acc_idx] <= acc_dat;
    end
  end

  assign wb.dat_o = rd_data;
  assign wb.ack_o = ack;
  assign wb.err_o = err;

endmodule : wb_sram_slave
